// File: rtl/div16_seq.sv
// ---------------------------------------------------------------------------
// div16_seq -- iterative restoring divider (one trial subtraction per clock)
//
// Computes quotient and remainder of two WIDTH-bit operands through a
// start/done handshake. An operation is accepted only while idle. With a
// non-zero divisor, busy is high for WIDTH cycles and is followed by a
// one-cycle done pulse. With a zero divisor, done follows the accepting edge
// directly. In that case quotient is all ones, remainder is the dividend and
// div_by_zero is set.
//
// Optional build macro:
//   SIGNED_DIV_EN  adds the is_signed input. Signed operations divide the
//                  operand magnitudes on the same unsigned core. The signs
//                  are then fixed up on the edge that writes the results.
//
// Ports:
//   clk          system clock, rising-edge
//   rst          synchronous reset, active-high
//   start        request, sampled only in IDLE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   is_signed    (SIGNED_DIV_EN only) two's complement operands
//   busy         operation in progress
//   done         one-cycle completion pulse
//   quotient     result quotient, held until overwritten
//   remainder    result remainder, held until overwritten
//   div_by_zero  the captured divisor was zero
// ---------------------------------------------------------------------------
module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] rem_reg;       // partial remainder
    logic [WIDTH-1:0] shift_reg;     // dividend bits out at MSB, quotient bits in at LSB
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    logic sign_mode;
`ifdef SIGNED_DIV_EN
    assign sign_mode = is_signed;
`else
    assign sign_mode = 1'b0;
`endif

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             accept;
    logic             divisor_zero;

    assign dvd_neg      = sign_mode & dividend[WIDTH-1];
    assign dsr_neg      = sign_mode & divisor[WIDTH-1];
    // The magnitude of -2^(WIDTH-1) is itself read as unsigned. This makes
    // the overflow case (-2^(WIDTH-1) / -1) produce 2^(WIDTH-1) rem 0
    // without any special handling.
    assign dvd_mag      = dvd_neg ? -dividend : dividend;
    assign dsr_mag      = dsr_neg ? -divisor : divisor;
    assign accept       = (state_reg == S_IDLE) && start;
    assign divisor_zero = (divisor == '0);

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    // The whole previous remainder is kept in the shifted value, including
    // its MSB. A remainder can have its MSB set whenever the divisor is
    // above 2^(WIDTH-1), so a WIDTH+1 bit trial is required.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;
    logic             last_iter;

    assign shifted   = {rem_reg, shift_reg[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor_reg};
    assign borrow    = trial[WIDTH];
    // On a borrow, shifted < divisor, so it fits in WIDTH bits.
    assign rem_step  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_step    = {shift_reg[WIDTH-2:0], ~borrow};
    assign last_iter = (count_reg == CW'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_CALC:  busy = 1'b1;
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg       <= '0;
            divisor_reg     <= '0;
            rem_reg         <= '0;
            shift_reg       <= '0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else if (accept) begin
            divisor_reg     <= dsr_mag;
            rem_reg         <= '0;
            shift_reg       <= dvd_mag;
            count_reg       <= CW'(WIDTH);
            neg_q_reg       <= dvd_neg ^ dsr_neg;
            neg_r_reg       <= dvd_neg;
            div_by_zero_reg <= divisor_zero;
            if (divisor_zero) begin
                // Results are known immediately and FIN follows directly.
                quotient_reg  <= '1;
                remainder_reg <= dividend;
            end
        end else if (state_reg == S_CALC) begin
            rem_reg   <= rem_step;
            shift_reg <= q_step;
            count_reg <= count_reg - CW'(1);
            if (last_iter) begin
                // The sign fixup happens here, so negation adds no cycle.
                quotient_reg  <= neg_q_reg ? -q_step : q_step;
                remainder_reg <= neg_r_reg ? -rem_step : rem_step;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_div16_seq -- directed self-checking bench for div16_seq.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_div16_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total_cnt = 0;
    int pass_cnt  = 0;

    div16_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start pulse. It then waits (bounded) for done.
    // lat    : number of rising edges from and including the accepting edge
    //          to the first cycle where done is seen (-1 on timeout).
    // busy_n : number of sampled cycles in which busy was high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, output int lat, output int busy_n);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (busy) busy_n++;
        end
        if (!done) lat = -1;
        $display("op %h / %h signed=%0d -> q=%h r=%h dbz=%0d lat=%0d busy=%0d",
                 a, b, sgn, quotient, remainder, div_by_zero, lat, busy_n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags: got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder} !== 32'h0)
            $display("FAIL reset_results: got q=%h r=%h required 0000 0000", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat, bn;
        run_op(16'd100, 16'd7, 1'b0, lat, bn);
        total_cnt++;
        if (lat !== 17) $display("FAIL basic_latency: got %0d required 17", lat);
        else pass_cnt++;
        total_cnt++;
        if (bn !== 16) $display("FAIL basic_busy_cycles: got %0d required 16", bn);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0})
            $display("FAIL basic_result: got q=%h r=%h dbz=%b required 000e 0002 0", quotient, remainder, div_by_zero);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b required 0", done);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd14) $display("FAIL basic_hold: got q=%h required 000e", quotient);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'hFFFF, 16'h0000} || lat !== 17)
            $display("FAIL b2b_ffff_by_1: got q=%h r=%h lat=%0d required ffff 0000 17", quotient, remainder, lat);
        else pass_cnt++;
        step();
        run_op(16'd5, 16'd9, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'h0000, 16'h0005})
            $display("FAIL b2b_5_by_9: got q=%h r=%h required 0000 0005", quotient, remainder);
        else pass_cnt++;
        step();
        // Divisor above 2^15: the partial remainder has its MSB set.
        run_op(16'hFFFF, 16'h8001, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'h0001, 16'h7FFE})
            $display("FAIL b2b_large_divisor: got q=%h r=%h required 0001 7ffe", quotient, remainder);
        else pass_cnt++;
        step();
    endtask

    task automatic test_div_by_zero();
        int lat, bn;
        run_op(16'h1234, 16'h0000, 1'b0, lat, bn);
        total_cnt++;
        if (lat !== 1) $display("FAIL dbz_latency: got %0d required 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h1234, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b required ffff 1234 1", quotient, remainder, div_by_zero);
        else pass_cnt++;
        step();
        total_cnt++;
        if (div_by_zero !== 1'b1) $display("FAIL dbz_hold_idle: got %b required 1", div_by_zero);
        else pass_cnt++;
        // The next accepted start clears the flag.
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        total_cnt++;
        if ({busy, div_by_zero} !== 2'b10)
            $display("FAIL dbz_clear_on_start: got busy/dbz=%b required 10", {busy, div_by_zero});
        else pass_cnt++;
        for (int i = 0; i < 40 && !done; i++) step();
        total_cnt++;
        if ({done, quotient, remainder} !== {1'b1, 16'd10, 16'd0})
            $display("FAIL dbz_followup: got done=%b q=%h r=%h required 1 000a 0000", done, quotient, remainder);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_calc();
        int done_seen;
        int lat, bn;
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, quotient, remainder} !== {2'b00, 32'h0})
            $display("FAIL midreset_state: got busy=%b done=%b q=%h r=%h required 0 0 0000 0000", busy, done, quotient, remainder);
        else pass_cnt++;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0) $display("FAIL midreset_no_done: got %0d active cycles required 0", done_seen);
        else pass_cnt++;
        run_op(16'd200, 16'd9, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'd22, 16'd2} || lat !== 17)
            $display("FAIL midreset_restart: got q=%h r=%h lat=%0d required 0016 0002 17", quotient, remainder, lat);
        else pass_cnt++;
        step();
    endtask

    task automatic test_start_held();
        int lat;
        dividend = 16'd1000;
        divisor  = 16'd30;
        start    = 1'b1;
        step();
        lat = 1;
        while (!done && lat < 40) begin
            dividend = 16'(lat * 37 + 11);
            divisor  = 16'(lat % 3);
            step();
            lat++;
        end
        total_cnt++;
        if (lat !== 17) $display("FAIL held_latency: got %0d required 17", lat);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder} !== {16'd33, 16'd10})
            $display("FAIL held_result: got q=%h r=%h required 0021 000a", quotient, remainder);
        else pass_cnt++;
        $display("op held 1000 / 30 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
        // start is still high in FIN and must be ignored there.
        dividend = 16'd9999;
        divisor  = 16'd0;
        step();
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL held_fin_ignored: got busy/done=%b required 00", {busy, done});
        else pass_cnt++;
        dividend = 16'd500;
        divisor  = 16'd7;
        step();
        start = 1'b0;
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL held_first_idle_accept: got busy/done=%b required 10", {busy, done});
        else pass_cnt++;
        for (int i = 0; i < 40 && !done; i++) step();
        total_cnt++;
        if ({done, quotient, remainder} !== {1'b1, 16'd71, 16'd3})
            $display("FAIL held_second_op: got done=%b q=%h r=%h required 1 0047 0003", done, quotient, remainder);
        else pass_cnt++;
        step();
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int lat, bn;
        run_op(16'hFFF9, 16'h0002, 1'b1, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'hFFFD, 16'hFFFF} || lat !== 17)
            $display("FAIL signed_m7_by_2: got q=%h r=%h lat=%0d required fffd ffff 17", quotient, remainder, lat);
        else pass_cnt++;
        step();
        run_op(16'h8000, 16'hFFFF, 1'b1, lat, bn);
        total_cnt++;
        if ({quotient, remainder} !== {16'h8000, 16'h0000})
            $display("FAIL signed_overflow: got q=%h r=%h required 8000 0000", quotient, remainder);
        else pass_cnt++;
        step();
        run_op(16'hFFF9, 16'h0000, 1'b1, lat, bn);
        total_cnt++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'hFFF9, 1'b1})
            $display("FAIL signed_dbz: got q=%h r=%h dbz=%b required ffff fff9 1", quotient, remainder, div_by_zero);
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_reset_mid_calc();
        test_start_held();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
